// File: rtl/MD_pkg.sv
// MD_pkg: shared definitions for the force output ring.
//   GLOBAL_CELL_ID_WIDTH   - bits per cell coordinate field (X, Y, Z)
//   force_pkt_t            - particle id plus fixed-point Fx, Fy, Fz
//   FORCE_PKT_STRUCT_WIDTH - packed width of force_pkt_t
//   FORCE_RING_FIFO_DEPTH  - default local injection FIFO depth
package MD_pkg;

  localparam int GLOBAL_CELL_ID_WIDTH = 3;
  localparam int PARTICLE_ID_WIDTH    = 8;
  localparam int FORCE_W              = 16;

  typedef struct packed {
    logic [PARTICLE_ID_WIDTH-1:0] pid;
    logic signed [FORCE_W-1:0]    fx;
    logic signed [FORCE_W-1:0]    fy;
    logic signed [FORCE_W-1:0]    fz;
  } force_pkt_t;

  localparam int FORCE_PKT_STRUCT_WIDTH = $bits(force_pkt_t);
  localparam int FORCE_RING_FIFO_DEPTH  = 8;

endpackage

// File: rtl/force_output_ring.sv
// force_output_ring: NUM_CELLS force_output_ring_node instances closed into a
// ring. Node i takes its upstream slot from node (i+1) % NUM_CELLS. Cells are
// laid out along X (node i is cell (i, GCELL_Y, GCELL_Z)).
//   Per-node local PE and force cache ports are exposed as packed arrays.
//   FORCE_RING_PERF_EN adds per-node counter outputs.
module force_output_ring import MD_pkg::*; #(
  parameter int NUM_CELLS = 4,
  parameter int GCELL_Y   = 0,
  parameter int GCELL_Z   = 0
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic [NUM_CELLS-1:0][FORCE_PKT_STRUCT_WIDTH-1:0]     local_force_pkt,
  input  logic [NUM_CELLS-1:0][3*GLOBAL_CELL_ID_WIDTH-1:0]     local_dst_gcid,
  input  logic [NUM_CELLS-1:0]                                 local_valid,
  output logic [NUM_CELLS-1:0]                                 local_ready,
  input  logic [NUM_CELLS-1:0]                                 force_cache_ready,
`ifdef FORCE_RING_PERF_EN
  output logic [NUM_CELLS-1:0][31:0]                           deliver_cnt,
  output logic [NUM_CELLS-1:0][31:0]                           recirc_cnt,
  output logic [NUM_CELLS-1:0][31:0]                           inject_stall_cnt,
`endif
  output logic [NUM_CELLS-1:0][FORCE_PKT_STRUCT_WIDTH-1:0]     force_to_cache,
  output logic [NUM_CELLS-1:0]                                 force_to_cache_valid
);
  logic [NUM_CELLS-1:0][FORCE_PKT_STRUCT_WIDTH-1:0] ring_pkt;
  logic [NUM_CELLS-1:0][3*GLOBAL_CELL_ID_WIDTH-1:0] ring_gcid;
  logic [NUM_CELLS-1:0]                             ring_valid;

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_node
    localparam int UP = (i + 1) % NUM_CELLS;
    force_output_ring_node #(
      .GCELL_X (i),
      .GCELL_Y (GCELL_Y),
      .GCELL_Z (GCELL_Z)
    ) u_node (
      .clk                    (clk),
      .rst                    (rst),
      .i_ring_force_pkt       (ring_pkt[UP]),
      .i_ring_gcid            (ring_gcid[UP]),
      .i_ring_valid           (ring_valid[UP]),
      .i_local_force_pkt      (local_force_pkt[i]),
      .i_local_dst_gcid       (local_dst_gcid[i]),
      .i_local_valid          (local_valid[i]),
      .o_local_ready          (local_ready[i]),
      .i_force_cache_ready    (force_cache_ready[i]),
      .o_ring_force_pkt       (ring_pkt[i]),
      .o_ring_gcid            (ring_gcid[i]),
      .o_ring_valid           (ring_valid[i]),
`ifdef FORCE_RING_PERF_EN
      .o_deliver_cnt          (deliver_cnt[i]),
      .o_recirc_cnt           (recirc_cnt[i]),
      .o_inject_stall_cnt     (inject_stall_cnt[i]),
`endif
      .o_force_to_cache       (force_to_cache[i]),
      .o_force_to_cache_valid (force_to_cache_valid[i])
    );
  end

endmodule

// File: rtl/force_ring_fifo.sv
// force_ring_fifo: synchronous FIFO holding {gcid, pkt} for local injection.
//   clk, rst   - clock, asynchronous active-high reset (pointers and count)
//   push, din  - write strobe and data (ignored when full)
//   pop        - read strobe (ignored when empty)
//   dout       - head entry; a write into an empty FIFO appears here next cycle
//   full/empty - status flags
//   count      - occupancy, $clog2(DEPTH)+1 bits
module force_ring_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/force_output_ring_node.sv
// force_output_ring_node: one node of the force output ring.
//   Ring in  : i_ring_force_pkt, i_ring_gcid ({X,Y,Z}), i_ring_valid
//   Local PE : i_local_force_pkt, i_local_dst_gcid, i_local_valid, o_local_ready
//   Cache    : i_force_cache_ready, o_force_to_cache, o_force_to_cache_valid
//   Ring out : o_ring_force_pkt, o_ring_gcid, o_ring_valid (registered)
//   Optional : FORCE_RING_PERF_EN adds o_deliver_cnt, o_recirc_cnt,
//              o_inject_stall_cnt (32-bit saturating).
// Ring traffic has priority over the local FIFO for both the cache port and
// the outgoing slot; undeliverable hits recirculate so the ring never stalls.
module force_output_ring_node import MD_pkg::*; #(
  parameter int GCELL_X    = 0,
  parameter int GCELL_Y    = 0,
  parameter int GCELL_Z    = 0,
  parameter int FIFO_DEPTH = FORCE_RING_FIFO_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [FORCE_PKT_STRUCT_WIDTH-1:0]   i_ring_force_pkt,
  input  logic [3*GLOBAL_CELL_ID_WIDTH-1:0]   i_ring_gcid,
  input  logic                                i_ring_valid,
  input  logic [FORCE_PKT_STRUCT_WIDTH-1:0]   i_local_force_pkt,
  input  logic [3*GLOBAL_CELL_ID_WIDTH-1:0]   i_local_dst_gcid,
  input  logic                                i_local_valid,
  output logic                                o_local_ready,
  input  logic                                i_force_cache_ready,
  output logic [FORCE_PKT_STRUCT_WIDTH-1:0]   o_ring_force_pkt,
  output logic [3*GLOBAL_CELL_ID_WIDTH-1:0]   o_ring_gcid,
  output logic                                o_ring_valid,
`ifdef FORCE_RING_PERF_EN
  output logic [31:0]                         o_deliver_cnt,
  output logic [31:0]                         o_recirc_cnt,
  output logic [31:0]                         o_inject_stall_cnt,
`endif
  output logic [FORCE_PKT_STRUCT_WIDTH-1:0]   o_force_to_cache,
  output logic                                o_force_to_cache_valid
);
  localparam int GCID_W = 3 * GLOBAL_CELL_ID_WIDTH;
  localparam int PKT_W  = FORCE_PKT_STRUCT_WIDTH;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [GCID_W-1:0] MY_GCID = {GLOBAL_CELL_ID_WIDTH'(GCELL_X),
                                           GLOBAL_CELL_ID_WIDTH'(GCELL_Y),
                                           GLOBAL_CELL_ID_WIDTH'(GCELL_Z)};

  logic [GCID_W+PKT_W-1:0] fifo_head;
  logic [GCID_W-1:0]       head_gcid;
  logic [PKT_W-1:0]        head_pkt;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_push;
  logic                    fifo_pop;

  logic local_hit, ring_deliver, slot_busy, head_local, pop_cache, pop_ring;

  logic [PKT_W-1:0]  ring_pkt_p1;
  logic [GCID_W-1:0] ring_gcid_p1;
  logic              ring_vld_p1;
  logic [PKT_W-1:0]  cache_pkt_p1;
  logic              cache_vld_p1;

  // Ready is held low during reset so nothing is accepted into a clearing FIFO.
  assign o_local_ready = !rst && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign fifo_push     = i_local_valid && o_local_ready && !fifo_full;

  force_ring_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (GCID_W + PKT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   ({i_local_dst_gcid, i_local_force_pkt}),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {head_gcid, head_pkt} = fifo_head;

  assign local_hit    = i_ring_valid && (i_ring_gcid == MY_GCID);
  assign ring_deliver = local_hit && i_force_cache_ready;
  // Slot stays occupied by pass-through and recirculating packets.
  assign slot_busy    = i_ring_valid && !ring_deliver;
  assign head_local   = (head_gcid == MY_GCID);
  assign pop_cache    = !fifo_empty && head_local && !ring_deliver && i_force_cache_ready;
  assign pop_ring     = !fifo_empty && !head_local && !slot_busy;
  assign fifo_pop     = pop_cache || pop_ring;

  // ---- stage p1: registered ring slot and cache port ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_pkt_p1  <= '0;
      ring_gcid_p1 <= '0;
      ring_vld_p1  <= 1'b0;
      cache_pkt_p1 <= '0;
      cache_vld_p1 <= 1'b0;
    end else begin
      ring_vld_p1  <= slot_busy || pop_ring;
      ring_pkt_p1  <= slot_busy ? i_ring_force_pkt : head_pkt;
      ring_gcid_p1 <= slot_busy ? i_ring_gcid : head_gcid;
      cache_vld_p1 <= ring_deliver || pop_cache;
      cache_pkt_p1 <= ring_deliver ? i_ring_force_pkt : head_pkt;
    end
  end

  assign o_ring_force_pkt       = ring_pkt_p1;
  assign o_ring_gcid            = ring_gcid_p1;
  assign o_ring_valid           = ring_vld_p1;
  assign o_force_to_cache       = cache_pkt_p1;
  assign o_force_to_cache_valid = cache_vld_p1;

`ifdef FORCE_RING_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_deliver_cnt      <= '0;
      o_recirc_cnt       <= '0;
      o_inject_stall_cnt <= '0;
    end else begin
      o_deliver_cnt      <= sat_inc(o_deliver_cnt, ring_deliver || pop_cache);
      o_recirc_cnt       <= sat_inc(o_recirc_cnt, local_hit && !i_force_cache_ready);
      o_inject_stall_cnt <= sat_inc(o_inject_stall_cnt, !fifo_empty && !fifo_pop);
    end
  end
`endif

endmodule

// File: tb/tb_force_output_ring_node.sv
// Scoreboard bench for force_output_ring_node at cell (1,0,2).
module tb_force_output_ring_node;
  import MD_pkg::*;

  localparam int GCID_W = 3 * GLOBAL_CELL_ID_WIDTH;
  localparam int PKT_W  = FORCE_PKT_STRUCT_WIDTH;
  localparam logic [GCID_W-1:0] MY   = {3'd1, 3'd0, 3'd2};
  localparam logic [GCID_W-1:0] REM  = {3'd2, 3'd0, 3'd2};
  localparam logic [GCID_W-1:0] ZERO = '0;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [PKT_W-1:0]  i_ring_force_pkt = '0;
  logic [GCID_W-1:0] i_ring_gcid = '0;
  logic              i_ring_valid = 1'b0;
  logic [PKT_W-1:0]  i_local_force_pkt = '0;
  logic [GCID_W-1:0] i_local_dst_gcid = '0;
  logic              i_local_valid = 1'b0;
  logic              o_local_ready;
  logic              i_force_cache_ready = 1'b0;
  logic [PKT_W-1:0]  o_ring_force_pkt;
  logic [GCID_W-1:0] o_ring_gcid;
  logic              o_ring_valid;
  logic [PKT_W-1:0]  o_force_to_cache;
  logic              o_force_to_cache_valid;
`ifdef FORCE_RING_PERF_EN
  logic [31:0] o_deliver_cnt, o_recirc_cnt, o_inject_stall_cnt;
`endif

  force_output_ring_node #(.GCELL_X(1), .GCELL_Y(0), .GCELL_Z(2), .FIFO_DEPTH(8)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_ring_force_pkt       (i_ring_force_pkt),
    .i_ring_gcid            (i_ring_gcid),
    .i_ring_valid           (i_ring_valid),
    .i_local_force_pkt      (i_local_force_pkt),
    .i_local_dst_gcid       (i_local_dst_gcid),
    .i_local_valid          (i_local_valid),
    .o_local_ready          (o_local_ready),
    .i_force_cache_ready    (i_force_cache_ready),
    .o_ring_force_pkt       (o_ring_force_pkt),
    .o_ring_gcid            (o_ring_gcid),
    .o_ring_valid           (o_ring_valid),
`ifdef FORCE_RING_PERF_EN
    .o_deliver_cnt          (o_deliver_cnt),
    .o_recirc_cnt           (o_recirc_cnt),
    .o_inject_stall_cnt     (o_inject_stall_cnt),
`endif
    .o_force_to_cache       (o_force_to_cache),
    .o_force_to_cache_valid (o_force_to_cache_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [GCID_W-1:0] gcid;
    logic [PKT_W-1:0]  pkt;
  } exp_t;

  exp_t ring_q[$];
  exp_t cache_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [PKT_W-1:0] mkpkt(input logic [7:0] id);
    return {7{id}};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ring(input int c, input logic [GCID_W-1:0] g, input logic [PKT_W-1:0] p);
    exp_t e;
    e.cyc = c; e.gcid = g; e.pkt = p;
    ring_q.push_back(e);
  endtask

  task automatic exp_cache(input int c, input logic [PKT_W-1:0] p);
    exp_t e;
    e.cyc = c; e.gcid = '0; e.pkt = p;
    cache_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_ring_valid) begin
          checks++;
          if (ring_q.size() == 0) begin
            errors++;
            $display("FAIL ring_unexpected: got gcid=%0h pkt=%0h at cyc %0d, required no output",
                     o_ring_gcid, o_ring_force_pkt, cyc);
          end else begin
            e = ring_q.pop_front();
            if (e.cyc != cyc || e.gcid !== o_ring_gcid || e.pkt !== o_ring_force_pkt) begin
              errors++;
              $display("FAIL ring_out: got gcid=%0h pkt=%0h cyc=%0d, required gcid=%0h pkt=%0h cyc=%0d",
                       o_ring_gcid, o_ring_force_pkt, cyc, e.gcid, e.pkt, e.cyc);
            end
          end
        end else if (ring_q.size() > 0 && ring_q[0].cyc <= cyc) begin
          e = ring_q.pop_front();
          checks++; errors++;
          $display("FAIL ring_missing: got no output at cyc %0d, required pkt=%0h at cyc %0d",
                   cyc, e.pkt, e.cyc);
        end
        if (o_force_to_cache_valid) begin
          checks++;
          if (cache_q.size() == 0) begin
            errors++;
            $display("FAIL cache_unexpected: got pkt=%0h at cyc %0d, required no strobe",
                     o_force_to_cache, cyc);
          end else begin
            e = cache_q.pop_front();
            if (e.cyc != cyc || e.pkt !== o_force_to_cache) begin
              errors++;
              $display("FAIL cache_out: got pkt=%0h cyc=%0d, required pkt=%0h cyc=%0d",
                       o_force_to_cache, cyc, e.pkt, e.cyc);
            end
          end
        end else if (cache_q.size() > 0 && cache_q[0].cyc <= cyc) begin
          e = cache_q.pop_front();
          checks++; errors++;
          $display("FAIL cache_missing: got no strobe at cyc %0d, required pkt=%0h at cyc %0d",
                   cyc, e.pkt, e.cyc);
        end
      end
    end
  endtask

  initial begin
    int k;
    fork
      monitor();
    join_none

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst_ring_valid", 64'(o_ring_valid), 64'd0);
    check("rst_cache_valid", 64'(o_force_to_cache_valid), 64'd0);
    check("rst_local_ready", 64'(o_local_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(o_local_ready), 64'd1);

    // Ring hit, cache ready -> delivered, slot emptied
    i_ring_valid = 1'b1; i_ring_gcid = MY; i_ring_force_pkt = mkpkt(8'hA1);
    i_force_cache_ready = 1'b1;
    exp_cache(cyc + 1, mkpkt(8'hA1));
    tick();
    i_ring_valid = 1'b0;
    tick();

    // Ring hit, cache not ready -> recirculates unchanged
    i_ring_valid = 1'b1; i_ring_gcid = MY; i_ring_force_pkt = mkpkt(8'hA1);
    i_force_cache_ready = 1'b0;
    exp_ring(cyc + 1, MY, mkpkt(8'hA1));
    tick();
    i_ring_valid = 1'b0;
`ifdef FORCE_RING_PERF_EN
    check("deliver_cnt", 64'(o_deliver_cnt), 64'd1);
    check("recirc_cnt", 64'(o_recirc_cnt), 64'd1);
`endif
    tick();

    // Local packet to a remote cell, upstream idle -> ring two cycles later
    check("ready_before_push", 64'(o_local_ready), 64'd1);
    i_local_valid = 1'b1; i_local_dst_gcid = REM; i_local_force_pkt = mkpkt(8'hB2);
    exp_ring(cyc + 2, REM, mkpkt(8'hB2));
    tick();
    i_local_valid = 1'b0;
    repeat (3) tick();

    // Continuous upstream traffic, 9 pushes offered
    k = cyc;
    for (int j = 0; j < 10; j++) begin
      i_ring_valid = 1'b1; i_ring_gcid = ZERO; i_ring_force_pkt = mkpkt(8'h40 + 8'(j));
      exp_ring(cyc + 1, ZERO, mkpkt(8'h40 + 8'(j)));
      if (j < 9) begin
        check($sformatf("ready_fill_%0d", j), 64'(o_local_ready), (j < 8) ? 64'd1 : 64'd0);
        i_local_valid = 1'b1; i_local_dst_gcid = REM; i_local_force_pkt = mkpkt(8'hC0 + 8'(j));
      end else begin
        i_local_valid = 1'b0;
      end
      tick();
    end
    i_ring_valid = 1'b0;
    check("ready_full_on_pop", 64'(o_local_ready), 64'd0);
    for (int j = 0; j < 8; j++) exp_ring(k + 11 + j, REM, mkpkt(8'hC0 + 8'(j)));
    tick();
    check("ready_after_pop", 64'(o_local_ready), 64'd1);
    repeat (8) tick();
`ifdef FORCE_RING_PERF_EN
    check("inject_stall_cnt", 64'(o_inject_stall_cnt), 64'd9);
`endif

    // Ring hit beats a local-destined FIFO head for the cache port
    i_force_cache_ready = 1'b1;
    i_local_valid = 1'b1; i_local_dst_gcid = MY; i_local_force_pkt = mkpkt(8'hC5);
    tick();
    i_local_valid = 1'b0;
    i_ring_valid = 1'b1; i_ring_gcid = MY; i_ring_force_pkt = mkpkt(8'hD6);
    exp_cache(cyc + 1, mkpkt(8'hD6));
    exp_cache(cyc + 2, mkpkt(8'hC5));
    tick();
    i_ring_valid = 1'b0;
    repeat (3) tick();

    // Reset with 3 packets in the FIFO and a valid ring slot
    i_force_cache_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      i_local_valid = 1'b1; i_local_dst_gcid = MY; i_local_force_pkt = mkpkt(8'hE0 + 8'(j));
      if (j == 2) begin
        i_ring_valid = 1'b1; i_ring_gcid = ZERO; i_ring_force_pkt = mkpkt(8'hF7);
      end
      tick();
    end
    i_local_valid = 1'b0; i_ring_valid = 1'b0;
    check("ring_valid_pre_rst", 64'(o_ring_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("ring_valid_in_rst", 64'(o_ring_valid), 64'd0);
    check("ring_pkt_in_rst", 64'(o_ring_force_pkt), 64'd0);
    check("cache_valid_in_rst", 64'(o_force_to_cache_valid), 64'd0);
    check("ready_in_rst", 64'(o_local_ready), 64'd0);
`ifdef FORCE_RING_PERF_EN
    check("deliver_cnt_rst", 64'(o_deliver_cnt), 64'd0);
    check("stall_cnt_rst", 64'(o_inject_stall_cnt), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("ready_post_rst", 64'(o_local_ready), 64'd1);
    i_force_cache_ready = 1'b1;
    repeat (4) tick();
    check("ring_valid_post_rst", 64'(o_ring_valid), 64'd0);

    check("ring_q_drained", 64'(ring_q.size()), 64'd0);
    check("cache_q_drained", 64'(cache_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/force_output_ring_node.md
# force_output_ring_node

One node of the force output ring, which returns partial forces computed by the PEs to the force cache of each particle's home cell. The ring runs in the opposite direction to position distribution. Each node does three things: it accepts force packets from its local PE into a FIFO, injects them into empty ring slots, and delivers ring packets addressed to its own cell to the local force cache. Packets the cache cannot accept keep recirculating, so the ring never stalls.

## Interface
- GCELL_X, 0, global X coordinate of this node's home cell
- GCELL_Y, 0, global Y coordinate
- GCELL_Z, 0, global Z coordinate
- FIFO_DEPTH, FORCE_RING_FIFO_DEPTH (8), local injection FIFO depth; must be a power of 2 and at least 2
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- i_ring_force_pkt  in  FORCE_PKT_STRUCT_WIDTH  packet from the upstream node
- i_ring_gcid  in  3*GLOBAL_CELL_ID_WIDTH  destination cell of the upstream packet, packed {X,Y,Z} with X in the MSBs
- i_ring_valid  in  1  upstream slot occupied
- i_local_force_pkt  in  FORCE_PKT_STRUCT_WIDTH  force packet from the local PE
- i_local_dst_gcid  in  3*GLOBAL_CELL_ID_WIDTH  destination cell of the local packet
- i_local_valid  in  1  local packet offered
- o_local_ready  out  1  FIFO can accept a packet; a push occurs when valid and ready are both high
- i_force_cache_ready  in  1  local force cache can accept a packet this cycle
- o_ring_force_pkt / o_ring_gcid / o_ring_valid  out  as the ring inputs  slot sent to the downstream node
- o_force_to_cache  out  FORCE_PKT_STRUCT_WIDTH  packet delivered to the local force cache
- o_force_to_cache_valid  out  1  delivery strobe, one cycle per packet

## Operation
- Each cycle, define local_hit = i_ring_valid and i_ring_gcid == {GCELL_X,GCELL_Y,GCELL_Z}. Each coordinate field is GLOBAL_CELL_ID_WIDTH bits wide.
- **Deliver:** if local_hit and i_force_cache_ready, the arriving packet goes to the cache and the ring slot becomes empty.
- **Recirculate:** if local_hit and the cache is not ready, the packet passes downstream unchanged. It returns after one full ring lap.
- **Pass through:** non-hit valid packets always pass downstream.
- **FIFO head, local destination:** if the head is addressed to this node's cell, it may pop to the cache only when all of the following hold:
  - no ring delivery happened this cycle;
  - i_force_cache_ready is high;
  - the FIFO is non-empty.
- **FIFO head, remote destination:** if the head is addressed elsewhere, it pops into the ring slot only when the slot is empty after the deliver/pass decision.
- Priority: ring traffic always wins over local traffic, both for the cache port and for the slot. At most one FIFO pop per cycle.
- The FIFO has no bypass. A push into an empty FIFO is visible at the head in the following cycle.
- o_local_ready = (count < FIFO_DEPTH). The count is $clog2(FIFO_DEPTH)+1 bits wide.
- A push and a pop in the same cycle leave the count unchanged.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally.

## Timing
- Ring hop latency: 1 cycle. All ring outputs are registered.
- Ring arrival to cache strobe: 1 cycle. Cache outputs are registered.
- Local push to earliest ring or cache output: 2 cycles.
- Reset behaviour: all output valids, data, FIFO pointers and count are cleared to 0 immediately, asynchronously. o_local_ready is 0 while rst is high and becomes 1 in the first cycle after release.
- A reset mid-operation discards every packet on the ring and in the FIFO. No partial state survives.
- When the FIFO is full, o_local_ready is low for that cycle even if a pop occurs in the same cycle. Ready rises the cycle after the pop.
- i_force_cache_ready is sampled only in the cycle of the deliver decision. No handshake is held across cycles.

## Configuration
- **FORCE_RING_PERF_EN defined:** adds three 32-bit saturating output counters, o_deliver_cnt, o_recirc_cnt and o_inject_stall_cnt.
  - o_recirc_cnt counts local_hit cycles with the cache not ready.
  - o_inject_stall_cnt counts cycles where the FIFO head is non-empty but is blocked from both the ring slot and the cache port.
  - All three are cleared by rst.
- **Undefined:** these ports and their logic are absent. Functional behaviour is identical.

## Structure
- Shared package MD_pkg holds:
  - FORCE_PKT_STRUCT_WIDTH;
  - the force packet struct (particle id plus fixed-point Fx, Fy, Fz);
  - GLOBAL_CELL_ID_WIDTH;
  - FORCE_RING_FIFO_DEPTH.
- Sub-module force_ring_fifo is a synchronous FIFO holding {gcid, pkt}. It has push/pop, full/empty and a count output, and uses the same asynchronous reset.
- The ring-level wrapper instantiates NUM_CELLS nodes in a loop. Node i's upstream is node (i+1)%NUM_CELLS.

## Test plan
All scenarios use a node at (1,0,2).
- Ring packet with gcid (1,0,2), pkt A, cache ready -> o_force_to_cache = A with valid high one cycle later; o_ring_valid = 0.
- Same packet with the cache not ready -> o_ring_valid = 1 with A next cycle; no cache strobe; o_recirc_cnt = 1 when the macro is enabled.
- Push local packet B to (2,0,2) with the upstream idle -> o_ring_valid = 1 with B two cycles after the push.
- Continuous upstream traffic to (0,0,0) with 9 local pushes offered -> o_local_ready drops after 8 accepted pushes; nothing is injected; on the first idle upstream cycle the FIFO head leaves.
- Ring hit plus a local-destined FIFO head, cache ready -> the ring packet is delivered first and the FIFO packet the cycle after.
- Assert rst with 3 packets in the FIFO and a valid ring slot -> all valids drop immediately; after release the FIFO is empty and o_local_ready = 1.
